iter_shifter: RTL



---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_step.sv | 30 +++
 rtl/iter_shifter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared encodings and constants for the iterative operand shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam int unsigned SH_MAX_STEPS = 33;
    localparam int unsigned CNT_W        = 6;

endpackage

// File: rtl/shift_step.sv
// One-bit shift step: LSL/LSR/ASR/ROR. For ROR the incoming MSB comes from fill,
// which allows the same step to perform RRX.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  sh_type_e         sh_type,
    input  logic             fill,
    output logic [WIDTH-1:0] next_value,
    output logic             bit_out
);

    always_comb begin
        next_value = value;
        bit_out    = value[0];
        case (sh_type)
            SH_LSL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                bit_out    = value[WIDTH-1];
            end
            SH_LSR: next_value = {1'b0, value[WIDTH-1:1]};
            SH_ASR: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
            SH_ROR: next_value = {fill, value[WIDTH-1:1]};
            default: next_value = value;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Iterative ARM-style register shifter feeding ALU operand B and shiftCout.
// Optional SHIFT_RRX_EN adds the rrx input for single-step rotate-right-extended.
module iter_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         shtype,
    input  logic               c_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   dout,
    output logic               shift_cout
`ifdef SHIFT_RRX_EN
    ,
    input  logic               rrx
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] val_q;
    logic             carry_q;
    sh_type_e         type_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] n_eff;
    logic             accept;
    logic [WIDTH-1:0] step_val;
    logic             step_out;
    logic             step_fill;
`ifdef SHIFT_RRX_EN
    logic             rrx_q;
`endif

    assign accept      = start_valid && start_ready;
    assign start_ready = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign dout        = val_q;
    assign shift_cout  = carry_q;

    always_comb begin
        n_eff = '0;
        if (sh_type_e'(shtype) == SH_ROR) begin
            if ((shamt[4:0] == '0) && (shamt != '0))
                n_eff = CNT_W'(32);
            else
                n_eff = CNT_W'(shamt[4:0]);
        end else if (shamt > SHAMT_W'(SH_MAX_STEPS)) begin
            n_eff = CNT_W'(SH_MAX_STEPS);
        end else begin
            n_eff = CNT_W'(shamt);
        end
`ifdef SHIFT_RRX_EN
        if ((sh_type_e'(shtype) == SH_ROR) && (shamt == '0) && rrx)
            n_eff = CNT_W'(1);
`endif
    end

`ifdef SHIFT_RRX_EN
    assign step_fill = rrx_q ? carry_q : val_q[0];
`else
    assign step_fill = val_q[0];
`endif

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value      (val_q),
        .sh_type    (type_q),
        .fill       (step_fill),
        .next_value (step_val),
        .bit_out    (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // A zero count still passes through SHIFT for one idle cycle so the
    // result always appears max(N,1) edges after accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SHIFT;
            ST_SHIFT: if (count_q <= CNT_W'(1)) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q   <= '0;
            carry_q <= 1'b0;
            type_q  <= SH_LSL;
            count_q <= '0;
`ifdef SHIFT_RRX_EN
            rrx_q   <= 1'b0;
`endif
        end else if (accept) begin
            val_q   <= data_in;
            carry_q <= c_in;
            type_q  <= sh_type_e'(shtype);
            count_q <= n_eff;
`ifdef SHIFT_RRX_EN
            rrx_q   <= rrx && (sh_type_e'(shtype) == SH_ROR) && (shamt == '0);
`endif
        end else if ((state_q == ST_SHIFT) && (count_q != '0)) begin
            val_q   <= step_val;
            carry_q <= step_out;
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule
